// File: rtl/regfile_sb_pkg.sv
// Shared sizing helpers for the scoreboarded register file.
package regfile_sb_pkg;

   function automatic int unsigned addr_width(input int unsigned nregs);
      return (nregs < 2) ? 1 : $clog2(nregs);
   endfunction

   // Pending counters must hold 0..MAXPEND inclusive
   function automatic int unsigned cnt_width(input int unsigned maxpend);
      return (maxpend < 1) ? 1 : $clog2(maxpend + 1);
   endfunction

endpackage

// File: rtl/regfile_sb_if.sv
// Read, reservation, bypass and writeback bus of the scoreboarded register file.
interface regfile_sb_if
   import regfile_sb_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NREGS   = 32,
   parameter int unsigned NREAD   = 2,
   parameter int unsigned NBYPASS = 2
);
   localparam int unsigned AW = addr_width(NREGS);

   logic [NREAD*AW-1:0]     rs_address;
   logic [NREAD*XLEN-1:0]   rs_data;
   logic [NREAD-1:0]        rs_ready;
   logic                    issue_valid;
   logic [AW-1:0]           issue_address;
   logic                    issue_ready;
   logic [NBYPASS-1:0]      bypass_valid;
   logic [NBYPASS*AW-1:0]   bypass_address;
   logic [NBYPASS*XLEN-1:0] bypass_data;
   logic                    wb_valid;
   logic [AW-1:0]           wb_address;
   logic [XLEN-1:0]         wb_data;
   logic                    flush;
   logic                    sb_error;

   modport master (
      output rs_address, issue_valid, issue_address,
      output bypass_valid, bypass_address, bypass_data,
      output wb_valid, wb_address, wb_data, flush,
      input  rs_data, rs_ready, issue_ready, sb_error
   );

   modport slave (
      input  rs_address, issue_valid, issue_address,
      input  bypass_valid, bypass_address, bypass_data,
      input  wb_valid, wb_address, wb_data, flush,
      output rs_data, rs_ready, issue_ready, sb_error
   );
endinterface

// File: rtl/regfile_read_port.sv
// One operand read: x0 / bypass / writeback / storage forwarding plus readiness.
module regfile_read_port
   import regfile_sb_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned AW      = 5,
   parameter int unsigned CW      = 2,
   parameter int unsigned NBYPASS = 2
) (
   input  logic [AW-1:0]           address,
   input  logic [XLEN-1:0]         reg_data,
   input  logic [CW-1:0]           pend,
   input  logic [NBYPASS-1:0]      bypass_valid,
   input  logic [NBYPASS*AW-1:0]   bypass_address,
   input  logic [NBYPASS*XLEN-1:0] bypass_data,
   input  logic                    wb_valid,
   input  logic [AW-1:0]           wb_address,
   input  logic [XLEN-1:0]         wb_data,
   output logic [XLEN-1:0]         data,
   output logic                    ready
);
   logic hit;

   // Walk oldest to youngest so the lowest-index bypass has the final say
   always_comb begin
      data = reg_data;
      hit  = 1'b0;
      if (wb_valid && wb_address == address) begin
         data = wb_data;
         hit  = 1'b1;
      end
      for (int i = NBYPASS - 1; i >= 0; i--) begin
         if (bypass_valid[i] && bypass_address[i*AW +: AW] == address) begin
            data = bypass_data[i*XLEN +: XLEN];
            hit  = 1'b1;
         end
      end
      if (address == '0) data = '0;
   end

   assign ready = (address == '0) || (pend == '0) || (pend == CW'(1) && hit);

endmodule

// File: rtl/regfile_sb.sv
// Flop-based register file with per-register pending-write scoreboard and forwarding.
module regfile_sb
   import regfile_sb_pkg::*;
#(
   parameter int unsigned XLEN    = 32,
   parameter int unsigned NREGS   = 32,
   parameter int unsigned NREAD   = 2,
   parameter int unsigned NBYPASS = 2,
   parameter int unsigned MAXPEND = 3
) (
   input  logic         clk,
   input  logic         reset,
   regfile_sb_if.slave  bus
);
   localparam int unsigned AW = addr_width(NREGS);
   localparam int unsigned CW = cnt_width(MAXPEND);

   logic [XLEN-1:0]       regs     [NREGS];
   logic [CW-1:0]         pend     [NREGS];
   logic [CW-1:0]         pend_nxt [NREGS];
   logic                  sb_error_q;
   logic                  issue_ready_c;
   logic                  issue_fire_c;
   logic                  wb_live_c;
   logic                  underflow_c;
   logic [NREAD*XLEN-1:0] rs_data_c;
   logic [NREAD-1:0]      rs_ready_c;

   // A full register can still accept an issue when it retires a write this cycle
   assign issue_ready_c = reset ||
                          !(pend[bus.issue_address] == CW'(MAXPEND) &&
                            !(bus.wb_valid && bus.wb_address == bus.issue_address));
   assign issue_fire_c  = bus.issue_valid && issue_ready_c && (bus.issue_address != '0);
   assign wb_live_c     = bus.wb_valid && (bus.wb_address != '0);
   assign underflow_c   = wb_live_c && (pend[bus.wb_address] == '0) &&
                          !(issue_fire_c && bus.issue_address == bus.wb_address);

   // Pending counter next state; flush wins over issue and writeback
   always_comb begin
      for (int r = 0; r < NREGS; r++) begin
         pend_nxt[r] = pend[r];
         if (bus.flush) begin
            pend_nxt[r] = '0;
         end else if (issue_fire_c && bus.issue_address == AW'(r) &&
                      !(wb_live_c && bus.wb_address == AW'(r))) begin
            pend_nxt[r] = pend[r] + CW'(1);
         end else if (wb_live_c && bus.wb_address == AW'(r) &&
                      !(issue_fire_c && bus.issue_address == AW'(r)) &&
                      pend[r] != '0) begin
            pend_nxt[r] = pend[r] - CW'(1);
         end
      end
   end

   // Storage, counters and sticky error; x0 is never written
   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         for (int r = 0; r < NREGS; r++) begin
            regs[r] <= '0;
            pend[r] <= '0;
         end
         sb_error_q <= 1'b0;
      end else begin
         for (int r = 1; r < NREGS; r++) begin
            if (bus.wb_valid && bus.wb_address == AW'(r)) regs[r] <= bus.wb_data;
            pend[r] <= pend_nxt[r];
         end
         if (underflow_c) sb_error_q <= 1'b1;
      end
   end

   for (genvar g = 0; g < NREAD; g++) begin : g_rd
      logic [AW-1:0] addr;
      assign addr = bus.rs_address[g*AW +: AW];

      regfile_read_port #(
         .XLEN    (XLEN),
         .AW      (AW),
         .CW      (CW),
         .NBYPASS (NBYPASS)
      ) u_rd (
         .address        (addr),
         .reg_data       (regs[addr]),
         .pend           (pend[addr]),
         .bypass_valid   (bus.bypass_valid),
         .bypass_address (bus.bypass_address),
         .bypass_data    (bus.bypass_data),
         .wb_valid       (bus.wb_valid),
         .wb_address     (bus.wb_address),
         .wb_data        (bus.wb_data),
         .data           (rs_data_c[g*XLEN +: XLEN]),
         .ready          (rs_ready_c[g])
      );
   end

   assign bus.rs_data     = rs_data_c;
   assign bus.rs_ready    = rs_ready_c;
   assign bus.issue_ready = issue_ready_c;
   assign bus.sb_error    = sb_error_q;

endmodule

// File: tb/tb_regfile_sb.sv
// Self-checking bench for regfile_sb: vector table plus reset corner sequences.
module tb_regfile_sb;
   logic clk;
   logic reset;

   regfile_sb_if #(.XLEN(32), .NREGS(32), .NREAD(2), .NBYPASS(2)) bus ();

   regfile_sb #(
      .XLEN(32), .NREGS(32), .NREAD(2), .NBYPASS(2), .MAXPEND(3)
   ) dut (
      .clk   (clk),
      .reset (reset),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        iv;
      logic [4:0]  ia;
      logic        wv;
      logic [4:0]  wa;
      logic [31:0] wd;
      logic [1:0]  bv;
      logic [4:0]  ba0;
      logic [31:0] bd0;
      logic [4:0]  ba1;
      logic [31:0] bd1;
      logic        fl;
      logic [4:0]  ra0;
      logic [4:0]  ra1;
      logic [31:0] e_d0;
      logic [31:0] e_d1;
      logic [1:0]  e_rdy;
      logic        e_ir;
      logic        e_err;
   } vec_t;

   typedef struct {
      string       name;
      logic [63:0] exp;
   } sb_t;

   vec_t tbl[$];
   sb_t  sbq[$];
   int   n_chk  = 0;
   int   n_pass = 0;

   function automatic vec_t mk(
      int unsigned iv, int unsigned ia, int unsigned wv, int unsigned wa, int unsigned wd,
      int unsigned bv, int unsigned ba0, int unsigned bd0, int unsigned ba1, int unsigned bd1,
      int unsigned fl, int unsigned ra0, int unsigned ra1,
      int unsigned e_d0, int unsigned e_d1, int unsigned e_rdy, int unsigned e_ir,
      int unsigned e_err);
      vec_t v;
      v.iv = 1'(iv);   v.ia = 5'(ia);
      v.wv = 1'(wv);   v.wa = 5'(wa);   v.wd = 32'(wd);
      v.bv = 2'(bv);   v.ba0 = 5'(ba0); v.bd0 = 32'(bd0);
      v.ba1 = 5'(ba1); v.bd1 = 32'(bd1);
      v.fl = 1'(fl);   v.ra0 = 5'(ra0); v.ra1 = 5'(ra1);
      v.e_d0 = 32'(e_d0); v.e_d1 = 32'(e_d1); v.e_rdy = 2'(e_rdy);
      v.e_ir = 1'(e_ir);  v.e_err = 1'(e_err);
      return v;
   endfunction

   task automatic drive(input vec_t v);
      bus.issue_valid    = v.iv;
      bus.issue_address  = v.ia;
      bus.wb_valid       = v.wv;
      bus.wb_address     = v.wa;
      bus.wb_data        = v.wd;
      bus.bypass_valid   = v.bv;
      bus.bypass_address = {v.ba1, v.ba0};
      bus.bypass_data    = {v.bd1, v.bd0};
      bus.flush          = v.fl;
      bus.rs_address     = {v.ra1, v.ra0};
   endtask

   task automatic push(input string name, input logic [63:0] exp);
      sb_t s;
      s.name = name;
      s.exp  = exp;
      sbq.push_back(s);
   endtask

   task automatic pop_cmp(input logic [63:0] act);
      sb_t s;
      n_chk++;
      if (sbq.size() == 0) begin
         $display("FAIL scoreboard_empty: got 0x%0h, nothing expected", act);
      end else begin
         s = sbq.pop_front();
         if (act === s.exp) n_pass++;
         else $display("FAIL %s: got 0x%0h, want 0x%0h", s.name, act, s.exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   vec_t idle;

   initial begin
      idle = mk(0,0,0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0);
      reset = 1'b1;
      drive(idle);

      //     iv ia wv wa wd           bv ba0 bd0  ba1 bd1  fl ra0 ra1  e_d0         e_d1        rdy ir err
      tbl.push_back(mk(0,0, 0,0,0,          0,0,0,    0,0,     0, 5,0,  0,           0,           3,1,0));
      tbl.push_back(mk(1,5, 0,0,0,          0,0,0,    0,0,     0, 5,7,  0,           0,           3,1,0));
      tbl.push_back(mk(0,5, 1,5,32'hDEADBEEF,0,0,0,    0,0,     0, 5,5,  32'hDEADBEEF,32'hDEADBEEF,3,1,0));
      tbl.push_back(mk(0,0, 0,0,0,          0,0,0,    0,0,     0, 5,0,  32'hDEADBEEF,0,           3,1,0));
      tbl.push_back(mk(1,7, 0,0,0,          0,0,0,    0,0,     0, 7,5,  0,           32'hDEADBEEF,3,1,0));
      tbl.push_back(mk(0,0, 0,0,0,          0,0,0,    0,0,     0, 7,7,  0,           0,           0,1,0));
      tbl.push_back(mk(0,0, 0,0,0,          2,0,0,    7,32'h11,0, 7,7,  32'h11,      32'h11,      3,1,0));
      tbl.push_back(mk(0,0, 0,0,0,          3,7,32'h22,7,32'h11,0, 7,7,  32'h22,      32'h22,      3,1,0));
      tbl.push_back(mk(0,0, 0,0,0,          0,0,0,    0,0,     0, 7,5,  0,           32'hDEADBEEF,2,1,0));
      tbl.push_back(mk(0,0, 1,7,32'h77,     2,0,0,    7,32'h11,0, 7,7,  32'h11,      32'h11,      3,1,0));
      tbl.push_back(mk(0,0, 0,0,0,          0,0,0,    0,0,     0, 7,0,  32'h77,      0,           3,1,0));
      // x3 reservations up to the in-flight limit
      tbl.push_back(mk(1,3, 0,0,0,          0,0,0,    0,0,     0, 3,0,  0,           0,           3,1,0));
      tbl.push_back(mk(1,3, 0,0,0,          0,0,0,    0,0,     0, 3,0,  0,           0,           2,1,0));
      tbl.push_back(mk(1,3, 0,0,0,          0,0,0,    0,0,     0, 3,0,  0,           0,           2,1,0));
      tbl.push_back(mk(1,3, 0,0,0,          0,0,0,    0,0,     0, 3,0,  0,           0,           2,0,0));
      tbl.push_back(mk(1,3, 1,3,32'h33,     0,0,0,    0,0,     0, 3,0,  32'h33,      0,           2,1,0));
      tbl.push_back(mk(0,3, 0,0,0,          0,0,0,    0,0,     0, 3,0,  32'h33,      0,           2,0,0));
      tbl.push_back(mk(0,3, 1,3,32'h34,     0,0,0,    0,0,     1, 3,0,  32'h34,      0,           2,1,0));
      tbl.push_back(mk(0,3, 0,0,0,          0,0,0,    0,0,     0, 3,3,  32'h34,      32'h34,      3,1,0));
      // flush clears x4/x8 reservations
      tbl.push_back(mk(1,4, 0,0,0,          0,0,0,    0,0,     0, 4,8,  0,           0,           3,1,0));
      tbl.push_back(mk(1,8, 0,0,0,          0,0,0,    0,0,     0, 4,8,  0,           0,           2,1,0));
      tbl.push_back(mk(0,0, 0,0,0,          0,0,0,    0,0,     1, 4,8,  0,           0,           0,1,0));
      tbl.push_back(mk(0,0, 0,0,0,          0,0,0,    0,0,     0, 4,8,  0,           0,           3,1,0));
      // x0 ignores everything
      tbl.push_back(mk(1,0, 1,0,32'hFFFFFFFF,1,0,32'hAA,0,0,    0, 0,0,  0,           0,           3,1,0));
      tbl.push_back(mk(0,0, 0,0,0,          0,0,0,    0,0,     0, 0,0,  0,           0,           3,1,0));
      // issue and writeback together on an idle register: no underflow
      tbl.push_back(mk(1,10,1,10,32'h10,    0,0,0,    0,0,     0, 10,0, 32'h10,      0,           3,1,0));
      tbl.push_back(mk(0,0, 0,0,0,          0,0,0,    0,0,     0, 10,0, 32'h10,      0,           3,1,0));
      // writeback with nothing pending: data lands, error sticks
      tbl.push_back(mk(0,0, 1,9,32'h99,     0,0,0,    0,0,     0, 9,0,  32'h99,      0,           3,1,0));
      tbl.push_back(mk(0,0, 0,0,0,          0,0,0,    0,0,     0, 9,0,  32'h99,      0,           3,1,1));
      tbl.push_back(mk(0,0, 0,0,0,          0,0,0,    0,0,     0, 9,0,  32'h99,      0,           3,1,1));

      repeat (2) @(posedge clk);
      #1;
      reset = 1'b0;

      foreach (tbl[i]) begin
         drive(tbl[i]);
         push($sformatf("row%0d_d0", i),    64'(tbl[i].e_d0));
         push($sformatf("row%0d_d1", i),    64'(tbl[i].e_d1));
         push($sformatf("row%0d_ready", i), 64'(tbl[i].e_rdy));
         push($sformatf("row%0d_iready", i),64'(tbl[i].e_ir));
         push($sformatf("row%0d_err", i),   64'(tbl[i].e_err));
         #2;
         pop_cmp(64'(bus.rs_data[31:0]));
         pop_cmp(64'(bus.rs_data[63:32]));
         pop_cmp(64'(bus.rs_ready));
         pop_cmp(64'(bus.issue_ready));
         pop_cmp(64'(bus.sb_error));
         next_cycle();
      end

      // Async reset between edges with x12 reservations and a sticky error
      drive(mk(1,12, 0,0,0, 0,0,0,0,0, 0,0,0, 0,0,0,0,0));
      next_cycle();
      next_cycle();
      drive(mk(0,12, 0,0,0, 0,0,0,0,0, 0,12,5, 0,0,0,0,0));
      push("pre_reset_ready", 64'(2'b10));
      push("pre_reset_x5",    64'(32'hDEADBEEF));
      push("pre_reset_err",   64'(1));
      #1;
      pop_cmp(64'(bus.rs_ready));
      pop_cmp(64'(bus.rs_data[63:32]));
      pop_cmp(64'(bus.sb_error));
      #1;
      reset = 1'b1;
      push("async_ready", 64'(2'b11));
      push("async_x5",    64'(0));
      push("async_err",   64'(0));
      push("async_iready",64'(1));
      #1;
      pop_cmp(64'(bus.rs_ready));
      pop_cmp(64'(bus.rs_data[63:32]));
      pop_cmp(64'(bus.sb_error));
      pop_cmp(64'(bus.issue_ready));

      // Edge while held in reset must not take writes or issues
      drive(mk(1,12, 1,5,32'h55, 0,0,0,0,0, 0,12,5, 0,0,0,0,0));
      next_cycle();
      push("in_reset_iready", 64'(1));
      pop_cmp(64'(bus.issue_ready));
      reset = 1'b0;
      drive(mk(0,12, 0,0,0, 0,0,0,0,0, 0,12,5, 0,0,0,0,0));
      push("post_reset_x5",    64'(0));
      push("post_reset_ready", 64'(2'b11));
      push("post_reset_err",   64'(0));
      #1;
      pop_cmp(64'(bus.rs_data[63:32]));
      pop_cmp(64'(bus.rs_ready));
      pop_cmp(64'(bus.sb_error));

      // Counting from empty: three issues accepted, fourth refused
      for (int k = 0; k < 4; k++) begin
         drive(mk(1,12, 0,0,0, 0,0,0,0,0, 0,12,0, 0,0,0,0,0));
         push($sformatf("refill%0d_iready", k), 64'((k < 3) ? 1 : 0));
         #1;
         pop_cmp(64'(bus.issue_ready));
         next_cycle();
      end

      drive(idle);
      #1;
      if (sbq.size() != 0) begin
         n_chk++;
         $display("FAIL scoreboard_leftover: got %0d entries, want 0", sbq.size());
      end
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

   initial begin
      #100000;
      $display("FAIL timeout: got no finish, want finish before 100000");
      $fatal(1, "timeout");
   end

endmodule
